// File: rtl/btb_2bc_predictor.sv
// Direct-mapped branch target buffer with a saturating direction counter per
// entry. Fetch looks up the table combinationally to form next_PC; the resolve
// stage trains counters, allocates entries on taken misses and keeps
// saturating branch/mispredict statistics.
module btb_2bc_predictor #(
   parameter int WORD_SIZE  = 16,
   parameter int INDEX_BITS = 8,
   parameter int CNT_BITS   = 2,
   parameter int STAT_BITS  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WORD_SIZE-1:0] PC,
   output logic [WORD_SIZE-1:0] next_PC,
   output logic                 pred_hit,
   output logic                 pred_taken,
   input  logic                 upd_valid,
   input  logic [WORD_SIZE-1:0] upd_pc,
   input  logic                 upd_taken,
   input  logic [WORD_SIZE-1:0] upd_target,
   input  logic                 upd_mispredict,
   output logic [STAT_BITS-1:0] stat_branches,
   output logic [STAT_BITS-1:0] stat_mispredicts
);

   localparam int DEPTH    = 1 << INDEX_BITS;
   localparam int TAG_BITS = WORD_SIZE - INDEX_BITS;

   localparam logic [CNT_BITS-1:0]  CNT_MAX  = '1;
   localparam logic [CNT_BITS-1:0]  CNT_ZERO = '0;
   localparam logic [CNT_BITS-1:0]  CNT_ONE  = CNT_BITS'(1);
   // Freshly allocated entries start weakly taken (MSB set, rest clear).
   localparam logic [CNT_BITS-1:0]  CNT_INIT = {1'b1, {(CNT_BITS-1){1'b0}}};
   localparam logic [STAT_BITS-1:0] STAT_MAX = '1;
   localparam logic [STAT_BITS-1:0] STAT_ONE = STAT_BITS'(1);
   localparam logic [WORD_SIZE-1:0] PC_STEP  = WORD_SIZE'(1);

   // Entry storage
   logic                 valid_q  [DEPTH];
   logic [CNT_BITS-1:0]  cnt_q    [DEPTH];
   logic [TAG_BITS-1:0]  tag_q    [DEPTH];
   logic [WORD_SIZE-1:0] target_q [DEPTH];

   // Lookup-side field split
   logic [INDEX_BITS-1:0] look_idx;
   logic [TAG_BITS-1:0]   look_tag;

   // Update-side field split and decisions
   logic [INDEX_BITS-1:0] upd_idx;
   logic [TAG_BITS-1:0]   upd_tag;
   logic                  upd_hit;
   logic                  upd_write;
   logic [CNT_BITS-1:0]   cnt_nxt;

   assign look_idx = PC[INDEX_BITS-1:0];
   assign look_tag = PC[WORD_SIZE-1:INDEX_BITS];
   assign upd_idx  = upd_pc[INDEX_BITS-1:0];
   assign upd_tag  = upd_pc[WORD_SIZE-1:INDEX_BITS];

   // Fetch prediction: pre-update state only, no bypass from the update port.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      pred_hit   = 1'b0;
      pred_taken = 1'b0;
      next_PC    = PC + PC_STEP;
      if (valid_q[look_idx] && (tag_q[look_idx] == look_tag)) begin
         pred_hit   = 1'b1;
         pred_taken = cnt_q[look_idx][CNT_BITS-1];
      end
      if (pred_taken) begin
         next_PC = target_q[look_idx];
      end
   end

   // Training decision: hit moves the counter, taken miss allocates weakly taken.
   always_comb begin
      upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
      upd_write = upd_hit || upd_taken;
      cnt_nxt   = cnt_q[upd_idx];
      if (upd_hit) begin
         if (upd_taken) begin
            if (cnt_q[upd_idx] != CNT_MAX) cnt_nxt = cnt_q[upd_idx] + CNT_ONE;
         end else begin
            if (cnt_q[upd_idx] != CNT_ZERO) cnt_nxt = cnt_q[upd_idx] - CNT_ONE;
         end
      end else if (upd_taken) begin
         cnt_nxt = CNT_INIT;
      end
   end

   // Valid bits and counters: cleared together by reset, trained on accepted updates.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            // NOTE: sequential state is written with non-blocking assignments so all flops update together.
            valid_q[i] <= 1'b0;
            cnt_q[i]   <= CNT_ZERO;
         end
      end else if (upd_valid && upd_write) begin
         valid_q[upd_idx] <= 1'b1;
         cnt_q[upd_idx]   <= cnt_nxt;
      end
   end

   // Tag and target arrays: written on every taken update (hit refresh or allocation).
   always_ff @(posedge clk) begin
      // NOTE: tag/target are left out of reset on purpose; a cleared valid bit makes their contents irrelevant and keeps them RAM-friendly.
      if (!reset && upd_valid && upd_taken) begin
         tag_q[upd_idx]    <= upd_tag;
         target_q[upd_idx] <= upd_target;
      end
   end

   // Saturating statistics: count accepted updates and flagged mispredictions.
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else if (upd_valid) begin
         if (stat_branches != STAT_MAX) begin
            stat_branches <= stat_branches + STAT_ONE;
         end
         if (upd_mispredict && (stat_mispredicts != STAT_MAX)) begin
            stat_mispredicts <= stat_mispredicts + STAT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_btb_2bc_predictor.sv
// Directed bench for btb_2bc_predictor: a table of per-cycle vectors whose
// expected outputs reflect the state before that cycle's update edge, plus
// hand-written sequences for statistics, reset-vs-update and saturation.
module tb_btb_2bc_predictor;

   logic        clk;
   logic        reset;

   // Main instance (default parameters)
   logic [15:0] pc;
   logic [15:0] next_pc;
   logic        pred_hit;
   logic        pred_taken;
   logic        upd_valid;
   logic [15:0] upd_pc;
   logic        upd_taken;
   logic [15:0] upd_target;
   logic        upd_mispredict;
   logic [15:0] stat_branches;
   logic [15:0] stat_mispredicts;

   // Narrow-statistics instance
   logic [15:0] pc4;
   logic [15:0] next_pc4;
   logic        pred_hit4;
   logic        pred_taken4;
   logic        upd_valid4;
   logic [15:0] upd_pc4;
   logic        upd_taken4;
   logic [15:0] upd_target4;
   logic        upd_mispredict4;
   logic [3:0]  stat_branches4;
   logic [3:0]  stat_mispredicts4;

   int n_compared   = 0;
   int n_mismatched = 0;

   btb_2bc_predictor dut (
      .clk              (clk),
      .reset            (reset),
      .PC               (pc),
      .next_PC          (next_pc),
      .pred_hit         (pred_hit),
      .pred_taken       (pred_taken),
      .upd_valid        (upd_valid),
      .upd_pc           (upd_pc),
      .upd_taken        (upd_taken),
      .upd_target       (upd_target),
      .upd_mispredict   (upd_mispredict),
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
   );

   btb_2bc_predictor #(.STAT_BITS(4)) dut4 (
      .clk              (clk),
      .reset            (reset),
      .PC               (pc4),
      .next_PC          (next_pc4),
      .pred_hit         (pred_hit4),
      .pred_taken       (pred_taken4),
      .upd_valid        (upd_valid4),
      .upd_pc           (upd_pc4),
      .upd_taken        (upd_taken4),
      .upd_target       (upd_target4),
      .upd_mispredict   (upd_mispredict4),
      .stat_branches    (stat_branches4),
      .stat_mispredicts (stat_mispredicts4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] pc;
      logic        uv;
      logic [15:0] upc;
      logic        ut;
      logic [15:0] utgt;
      logic        um;
      logic        hit;
      logic        tk;
      logic [15:0] nxt;
      logic [15:0] br;
      logic [15:0] mis;
   } vec_t;

   localparam int N_VEC = 28;
   vec_t vecs [N_VEC];

   function automatic vec_t v(input logic [15:0] p, input logic uv, input logic [15:0] upc,
                              input logic ut, input logic [15:0] utgt, input logic um,
                              input logic hit, input logic tk, input logic [15:0] nxt,
                              input logic [15:0] br, input logic [15:0] mis);
      vec_t r;
      r.pc = p;  r.uv = uv; r.upc = upc; r.ut = ut; r.utgt = utgt; r.um = um;
      r.hit = hit; r.tk = tk; r.nxt = nxt; r.br = br; r.mis = mis;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      upd_valid      = 1'b0;
      upd_pc         = 16'h0000;
      upd_taken      = 1'b0;
      upd_target     = 16'h0000;
      upd_mispredict = 1'b0;
   endtask

   initial begin
      // cols: PC, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict | hit, taken, next_PC, branches, mispredicts
      vecs[0]  = v(16'h1234, 0, 16'h0000, 0, 16'h0000, 0,  0, 0, 16'h1235,  0, 0);
      vecs[1]  = v(16'hFFFF, 0, 16'h0000, 0, 16'h0000, 0,  0, 0, 16'h0000,  0, 0);
      vecs[2]  = v(16'h0310, 1, 16'h0310, 1, 16'h0020, 1,  0, 0, 16'h0311,  0, 0);
      vecs[3]  = v(16'h0310, 0, 16'h0000, 0, 16'h0000, 0,  1, 1, 16'h0020,  1, 1);
      vecs[4]  = v(16'h0310, 1, 16'h0310, 0, 16'h0000, 1,  1, 1, 16'h0020,  1, 1);
      vecs[5]  = v(16'h0310, 0, 16'h0000, 0, 16'h0000, 0,  1, 0, 16'h0311,  2, 2);
      vecs[6]  = v(16'h0310, 1, 16'h0310, 0, 16'h0000, 0,  1, 0, 16'h0311,  2, 2);
      vecs[7]  = v(16'h0310, 1, 16'h0310, 1, 16'h0020, 0,  1, 0, 16'h0311,  3, 2);
      vecs[8]  = v(16'h0310, 1, 16'h0310, 1, 16'h0020, 0,  1, 0, 16'h0311,  4, 2);
      vecs[9]  = v(16'h0310, 1, 16'h0310, 1, 16'h0020, 0,  1, 1, 16'h0020,  5, 2);
      vecs[10] = v(16'h0310, 1, 16'h0310, 1, 16'h0030, 0,  1, 1, 16'h0020,  6, 2);
      vecs[11] = v(16'h0310, 1, 16'h0310, 0, 16'h0000, 0,  1, 1, 16'h0030,  7, 2);
      vecs[12] = v(16'h0310, 1, 16'h0310, 0, 16'h0000, 0,  1, 1, 16'h0030,  8, 2);
      vecs[13] = v(16'h0310, 0, 16'h0000, 0, 16'h0000, 0,  1, 0, 16'h0311,  9, 2);
      vecs[14] = v(16'h0510, 1, 16'h0510, 1, 16'h0040, 1,  0, 0, 16'h0511,  9, 2);
      vecs[15] = v(16'h0310, 0, 16'h0000, 0, 16'h0000, 0,  0, 0, 16'h0311, 10, 3);
      vecs[16] = v(16'h0510, 1, 16'h0710, 0, 16'h0000, 0,  1, 1, 16'h0040, 10, 3);
      vecs[17] = v(16'h0510, 0, 16'h0000, 0, 16'h0000, 0,  1, 1, 16'h0040, 11, 3);
      vecs[18] = v(16'h0710, 0, 16'h0000, 0, 16'h0000, 0,  0, 0, 16'h0711, 11, 3);
      vecs[19] = v(16'h0420, 1, 16'h0420, 1, 16'h0123, 0,  0, 0, 16'h0421, 11, 3);
      vecs[20] = v(16'h0420, 0, 16'h0000, 0, 16'h0000, 0,  1, 1, 16'h0123, 12, 3);
      vecs[21] = v(16'h0420, 0, 16'h0420, 0, 16'h0777, 1,  1, 1, 16'h0123, 12, 3);
      vecs[22] = v(16'h0420, 0, 16'h0000, 0, 16'h0000, 0,  1, 1, 16'h0123, 12, 3);
      vecs[23] = v(16'h0420, 1, 16'h0420, 0, 16'h0000, 0,  1, 1, 16'h0123, 12, 3);
      vecs[24] = v(16'h0420, 1, 16'h0420, 0, 16'h0000, 0,  1, 0, 16'h0421, 13, 3);
      vecs[25] = v(16'h0420, 1, 16'h0420, 0, 16'h0000, 0,  1, 0, 16'h0421, 14, 3);
      vecs[26] = v(16'h0420, 1, 16'h0420, 1, 16'h0123, 0,  1, 0, 16'h0421, 15, 3);
      vecs[27] = v(16'h0420, 0, 16'h0000, 0, 16'h0000, 0,  1, 0, 16'h0421, 16, 3);

      // Initial reset of both instances
      reset           = 1'b1;
      pc              = 16'h0000;
      pc4             = 16'h0000;
      upd_valid4      = 1'b0;
      upd_pc4         = 16'h0000;
      upd_taken4      = 1'b0;
      upd_target4     = 16'h0000;
      upd_mispredict4 = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Table: drive at negedge, compare pre-edge outputs, update applies at next posedge
      for (int i = 0; i < N_VEC; i++) begin
         pc             = vecs[i].pc;
         upd_valid      = vecs[i].uv;
         upd_pc         = vecs[i].upc;
         upd_taken      = vecs[i].ut;
         upd_target     = vecs[i].utgt;
         upd_mispredict = vecs[i].um;
         #1;
         check($sformatf("vec%0d pred_hit", i),   {31'b0, pred_hit},   {31'b0, vecs[i].hit});
         check($sformatf("vec%0d pred_taken", i), {31'b0, pred_taken}, {31'b0, vecs[i].tk});
         check($sformatf("vec%0d next_PC", i),    {16'b0, next_pc},    {16'b0, vecs[i].nxt});
         check($sformatf("vec%0d stat_branches", i),    {16'b0, stat_branches},    {16'b0, vecs[i].br});
         check($sformatf("vec%0d stat_mispredicts", i), {16'b0, stat_mispredicts}, {16'b0, vecs[i].mis});
         @(negedge clk);
      end
      idle_inputs();

      // Reset mid-run, then five updates with two mispredicts
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      pc = 16'h0420;
      #1;
      check("midrun reset clears entry", {31'b0, pred_hit}, 32'd0);
      check("midrun reset next_PC", {16'b0, next_pc}, 32'h0421);
      check("midrun reset branches", {16'b0, stat_branches}, 32'd0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         upd_valid      = 1'b1;
         upd_pc         = 16'(k + 1);
         upd_taken      = 1'b1;
         upd_target     = 16'h0100;
         upd_mispredict = (k == 1) || (k == 3);
      end
      @(negedge clk);
      idle_inputs();
      #1;
      check("five updates branches", {16'b0, stat_branches}, 32'd5);
      check("five updates mispredicts", {16'b0, stat_mispredicts}, 32'd2);
      pc = 16'h0001;
      #1;
      check("allocated 0x0001 hit", {31'b0, pred_hit}, 32'd1);
      check("allocated 0x0001 next_PC", {16'b0, next_pc}, 32'h0100);

      // Reset concurrent with an update: update dropped, nothing counted
      @(negedge clk);
      reset          = 1'b1;
      upd_valid      = 1'b1;
      upd_pc         = 16'h0800;
      upd_taken      = 1'b1;
      upd_target     = 16'h0900;
      upd_mispredict = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      idle_inputs();
      pc = 16'h0800;
      #1;
      check("reset+update branches", {16'b0, stat_branches}, 32'd0);
      check("reset+update mispredicts", {16'b0, stat_mispredicts}, 32'd0);
      check("reset+update no alloc hit", {31'b0, pred_hit}, 32'd0);
      check("reset+update next_PC", {16'b0, next_pc}, 32'h0801);
      pc = 16'h0001;
      #1;
      check("reset clears old entry", {31'b0, pred_hit}, 32'd0);

      // Narrow statistics saturate rather than wrap
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         upd_valid4      = 1'b1;
         upd_pc4         = 16'(16'h0200 + k);
         upd_taken4      = k[0];
         upd_target4     = 16'h0300;
         upd_mispredict4 = 1'b1;
      end
      @(negedge clk);
      upd_valid4 = 1'b0;
      #1;
      check("stat4 branches saturate", {28'b0, stat_branches4}, 32'd15);
      check("stat4 mispredicts saturate", {28'b0, stat_mispredicts4}, 32'd15);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
